// File: rtl/bomberman_pkg.sv
// Shared bomberman definitions: tile geometry, bomb slot states, layer colours
// and the explosion-cross tile compare.
package bomberman_pkg;

    localparam int unsigned TILE_SHIFT = 5;

    localparam logic [11:0] BOMB_RGB = 12'h111;
    localparam logic [11:0] EXPL_RGB = 12'hF80;

    typedef logic [4:0] tile_t;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_FUSE    = 2'd1,
        SLOT_EXPLODE = 2'd2
    } slot_state_e;

    function automatic tile_t to_tile(input logic [9:0] pix);
        return pix[9:TILE_SHIFT];
    endfunction

    // Widened to 6 bits so neighbours past tile 0 or 31 never alias back into range
    function automatic logic in_cross(input tile_t cx, input tile_t cy,
                                      input tile_t px, input tile_t py);
        logic [5:0] cx6, cy6, px6, py6;
        logic       same_x, same_y, adj_x, adj_y;
        cx6    = {1'b0, cx};
        cy6    = {1'b0, cy};
        px6    = {1'b0, px};
        py6    = {1'b0, py};
        same_x = (px == cx);
        same_y = (py == cy);
        adj_x  = (px6 == cx6 + 6'd1) || (px6 + 6'd1 == cx6);
        adj_y  = (py6 == cy6 + 6'd1) || (py6 + 6'd1 == cy6);
        return (same_x && same_y) || (same_y && adj_x) || (same_x && adj_y);
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> FUSE -> EXPLODE lifecycle with tick counter,
// latched centre tile and a destroy-request flag that outlives the slot.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int unsigned FUSE_TICKS = 300,
    parameter int unsigned EXPL_TICKS = 50
) (
    input  logic        sys_clk,
    input  logic        Reset,
    input  logic        tick_i,
    input  logic        grant_i,
    input  logic        chain_i,
    input  logic        req_clr_i,
    input  tile_t       tx_i,
    input  tile_t       ty_i,
    output slot_state_e state_o,
    output tile_t       tx_o,
    output tile_t       ty_o,
    output logic        req_o
);

    localparam int unsigned CNT_MAX = (FUSE_TICKS > EXPL_TICKS) ? FUSE_TICKS : EXPL_TICKS;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] FUSE_LOAD = CW'(FUSE_TICKS - 1);
    localparam logic [CW-1:0] EXPL_LOAD = CW'(EXPL_TICKS - 1);

    slot_state_e   state_q;
    logic [CW-1:0] cnt_q;
    tile_t         tx_q, ty_q;
    logic          req_q;
    logic          fire;

    assign fire = (state_q == SLOT_FUSE) && (chain_i || (tick_i && cnt_q == '0));

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= SLOT_IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                SLOT_IDLE: begin
                    if (grant_i) begin
                        state_q <= SLOT_FUSE;
                        cnt_q   <= FUSE_LOAD;
                        tx_q    <= tx_i;
                        ty_q    <= ty_i;
                    end
                end
                SLOT_FUSE: begin
                    if (fire) begin
                        state_q <= SLOT_EXPLODE;
                        cnt_q   <= EXPL_LOAD;
                    end else if (tick_i) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SLOT_EXPLODE: begin
                    if (tick_i) begin
                        if (cnt_q == '0) state_q <= SLOT_IDLE;
                        else             cnt_q   <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= SLOT_IDLE;
            endcase
            // A fresh explosion outranks retiring a stale request from a previous life
            if (fire)           req_q <= 1'b1;
            else if (req_clr_i) req_q <= 1'b0;
        end
    end

    assign state_o = state_q;
    assign tx_o    = tx_q;
    assign ty_o    = ty_q;
    assign req_o   = req_q;

endmodule

// File: rtl/bomb_controller.sv
// Bomb scheduler: game-tick prescaler, placement allocator, slot array,
// destroy-request arbiter, sticky game-over and per-pixel layer enables.
module bomb_controller
    import bomberman_pkg::*;
#(
    parameter int unsigned NUM_BOMBS  = 2,
    parameter int unsigned TICK_DIV   = 1_000_000,
    parameter int unsigned FUSE_TICKS = 300,
    parameter int unsigned EXPL_TICKS = 50
) (
    input  logic        sys_clk,
    input  logic        Reset,
    input  logic        place,
    input  logic [9:0]  b_x,
    input  logic [9:0]  b_y,
    input  logic [9:0]  v_x,
    input  logic [9:0]  v_y,
    output logic        bomb_on,
    output logic        explosion_on,
    output logic [11:0] bomb_rgb,
    output logic [11:0] explosion_rgb,
    output logic        destroy_valid,
    output logic [4:0]  destroy_tx,
    output logic [4:0]  destroy_ty,
    input  logic        destroy_ready,
    output logic        game_over,
    output logic [1:0]  bombs_free
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IW = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;

    logic [PW-1:0]        presc_q;
    logic                 tick;
    logic                 place_q, place_prev_q, place_req;
    tile_t                bx_t, by_t, vx_t, vy_t;
    slot_state_e          st  [NUM_BOMBS];
    tile_t                stx [NUM_BOMBS];
    tile_t                sty [NUM_BOMBS];
    logic [NUM_BOMBS-1:0] slot_req, grant, chain, req_clr, req_eff, presented;
    logic                 dup, found, overlap, hs;
    int unsigned          n_free;
    logic [IW-1:0]        win_idx, dv_idx_q;
    logic                 dv_q, game_over_q;
    tile_t                dtx_q, dty_q;

    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign place_req = place_q & ~place_prev_q;
    assign bx_t      = to_tile(b_x);
    assign by_t      = to_tile(b_y);
    assign vx_t      = to_tile(v_x);
    assign vy_t      = to_tile(v_y);

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            presc_q      <= '0;
            place_q      <= 1'b0;
            place_prev_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            presc_q      <= tick ? '0 : presc_q + PW'(1);
            place_q      <= place;
            place_prev_q <= place_q;
            game_over_q  <= game_over_q | overlap;
        end
    end

    always_comb begin
        dup   = 1'b0;
        found = 1'b0;
        grant = '0;
        for (int unsigned i = 0; i < NUM_BOMBS; i++)
            if (st[i] != SLOT_IDLE && stx[i] == bx_t && sty[i] == by_t) dup = 1'b1;
        for (int unsigned i = 0; i < NUM_BOMBS; i++)
            if (!found && st[i] == SLOT_IDLE) begin
                found    = 1'b1;
                grant[i] = place_req & ~dup & ~game_over_q;
            end
    end

    always_comb begin
        chain        = '0;
        overlap      = 1'b0;
        bomb_on      = 1'b0;
        explosion_on = 1'b0;
        n_free       = 0;
        for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
            if (st[i] == SLOT_IDLE) n_free++;
            if (st[i] == SLOT_FUSE && stx[i] == vx_t && sty[i] == vy_t) bomb_on = 1'b1;
            if (st[i] == SLOT_EXPLODE) begin
                if (in_cross(stx[i], sty[i], vx_t, vy_t)) explosion_on = 1'b1;
                if (in_cross(stx[i], sty[i], bx_t, by_t)) overlap      = 1'b1;
                for (int unsigned j = 0; j < NUM_BOMBS; j++)
                    if (in_cross(stx[i], sty[i], stx[j], sty[j])) chain[j] = 1'b1;
            end
        end
    end

    // The presented slot's flag is masked out so the next winner can be loaded on the handshake edge
    always_comb begin
        hs                  = dv_q & destroy_ready;
        presented           = '0;
        presented[dv_idx_q] = 1'b1;
        req_clr             = hs ? presented : '0;
        req_eff             = slot_req & ~req_clr;
        win_idx             = '0;
        for (int unsigned i = NUM_BOMBS; i > 0; i--)
            if (req_eff[i-1]) win_idx = IW'(i - 1);
    end

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            dv_q     <= 1'b0;
            dv_idx_q <= '0;
            dtx_q    <= '0;
            dty_q    <= '0;
        end else if (!dv_q || destroy_ready) begin
            dv_q     <= |req_eff;
            dv_idx_q <= win_idx;
            dtx_q    <= stx[win_idx];
            dty_q    <= sty[win_idx];
        end
    end

    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
        bomb_slot #(
            .FUSE_TICKS(FUSE_TICKS),
            .EXPL_TICKS(EXPL_TICKS)
        ) u_slot (
            .sys_clk  (sys_clk),
            .Reset    (Reset),
            .tick_i   (tick),
            .grant_i  (grant[g]),
            .chain_i  (chain[g]),
            .req_clr_i(req_clr[g]),
            .tx_i     (bx_t),
            .ty_i     (by_t),
            .state_o  (st[g]),
            .tx_o     (stx[g]),
            .ty_o     (sty[g]),
            .req_o    (slot_req[g])
        );
    end

    assign bomb_rgb      = BOMB_RGB;
    assign explosion_rgb = EXPL_RGB;
    assign destroy_valid = dv_q;
    assign destroy_tx    = dtx_q;
    assign destroy_ty    = dty_q;
    assign game_over     = game_over_q;
    assign bombs_free    = 2'(n_free);

endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller: stimulus pushes expected destroy tiles,
// a monitor pops them on each destroy handshake.
module tb_bomb_controller;

    logic        sys_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        place = 1'b0;
    logic        destroy_ready = 1'b1;
    logic [9:0]  b_x = '0, b_y = '0, v_x = '0, v_y = '0;
    logic        bomb_on, explosion_on, destroy_valid, game_over;
    logic [11:0] bomb_rgb, explosion_rgb;
    logic [4:0]  destroy_tx, destroy_ty;
    logic [1:0]  bombs_free;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [9:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    bomb_controller #(
        .NUM_BOMBS (2),
        .TICK_DIV  (4),
        .FUSE_TICKS(3),
        .EXPL_TICKS(2)
    ) dut (
        .sys_clk      (sys_clk),
        .Reset        (Reset),
        .place        (place),
        .b_x          (b_x),
        .b_y          (b_y),
        .v_x          (v_x),
        .v_y          (v_y),
        .bomb_on      (bomb_on),
        .explosion_on (explosion_on),
        .bomb_rgb     (bomb_rgb),
        .explosion_rgb(explosion_rgb),
        .destroy_valid(destroy_valid),
        .destroy_tx   (destroy_tx),
        .destroy_ty   (destroy_ty),
        .destroy_ready(destroy_ready),
        .game_over    (game_over),
        .bombs_free   (bombs_free)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic set_v(input logic [4:0] tx, input logic [4:0] ty);
        v_x = {tx, 5'd8};
        v_y = {ty, 5'd8};
        #1;
    endtask

    task automatic probe_e(input string name, input logic [4:0] tx, input logic [4:0] ty, input logic exp);
        set_v(tx, ty);
        chk(name, explosion_on, exp);
    endtask

    task automatic probe_b(input string name, input logic [4:0] tx, input logic [4:0] ty, input logic exp);
        set_v(tx, ty);
        chk(name, bomb_on, exp);
    endtask

    task automatic place_at(input logic [9:0] x, input logic [9:0] y);
        b_x   = x;
        b_y   = y;
        place = 1'b1;
        step(2);
        place = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bombs_free != 2'd2 && n < 80) begin
            step(1);
            n++;
        end
        chk(name, bombs_free, 2);
    endtask

    // Destroy monitor
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge sys_clk);
            if (destroy_valid && destroy_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL destroy_unexpected: got tile (%0d,%0d), expected no request",
                             destroy_tx, destroy_ty);
                end else begin
                    e = exp_q.pop_front();
                    chk("destroy_tile", {destroy_tx, destroy_ty}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int n, dvc, hold;

        // Reset state
        step(2);
        chk("rst_valid", destroy_valid, 0);
        chk("rst_tx", destroy_tx, 0);
        chk("rst_ty", destroy_ty, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_free", bombs_free, 2);
        chk("rst_bomb_on", bomb_on, 0);
        chk("rst_expl_on", explosion_on, 0);
        chk("bomb_rgb", bomb_rgb, 12'h111);
        chk("expl_rgb", explosion_rgb, 12'hF80);
        Reset = 1'b0;
        step(2);

        // T1: single bomb at tile (2,3)
        place_at(10'd64, 10'd96);
        v_x = 10'd70; v_y = 10'd100; #1;
        chk("t1_bomb_on", bomb_on, 1);
        chk("t1_free", bombs_free, 1);
        b_x = 10'd320; b_y = 10'd320;
        exp_q.push_back({5'd2, 5'd3});
        n = 0;
        while (!explosion_on && n < 40) begin
            step(1);
            n++;
        end
        chk("t1_expl_centre", explosion_on, 1);
        chk("t1_fuse_len_in_9_12", (n >= 9 && n <= 12), 1);
        dvc = destroy_valid;
        probe_e("t1_x_1_3", 5'd1, 5'd3, 1);
        probe_e("t1_x_3_3", 5'd3, 5'd3, 1);
        probe_e("t1_x_2_2", 5'd2, 5'd2, 1);
        step(1);
        dvc += destroy_valid;
        probe_e("t1_x_2_4", 5'd2, 5'd4, 1);
        probe_e("t1_x_3_4", 5'd3, 5'd4, 0);
        probe_b("t1_no_bomb", 5'd2, 5'd3, 0);
        n = 0;
        while (bombs_free != 2'd2 && n < 40) begin
            step(1);
            dvc += destroy_valid;
            n++;
        end
        chk("t1_idle", bombs_free, 2);
        chk("t1_valid_cycles", dvc, 1);
        step(1);

        // T2: allocation, duplicate tile, pool exhaustion
        place_at(10'd100, 10'd100);
        step(1);
        chk("t2_free_1", bombs_free, 1);
        exp_q.push_back({5'd3, 5'd3});
        place_at(10'd100, 10'd100);
        step(1);
        chk("t2_dup_dropped", bombs_free, 1);
        place_at(10'd200, 10'd200);
        step(1);
        chk("t2_free_0", bombs_free, 0);
        exp_q.push_back({5'd6, 5'd6});
        place_at(10'd300, 10'd300);
        step(1);
        b_x = 10'd320; b_y = 10'd320;
        chk("t2_third_dropped", bombs_free, 0);
        probe_b("t2_no_bomb_9_9", 5'd9, 5'd9, 0);
        wait_idle("t2_idle");
        step(1);

        // T3: corner bomb at tile (0,0)
        place_at(10'd0, 10'd0);
        step(1);
        b_x = 10'd320; b_y = 10'd320;
        exp_q.push_back({5'd0, 5'd0});
        set_v(5'd0, 5'd0);
        n = 0;
        while (!explosion_on && n < 40) begin
            step(1);
            n++;
        end
        chk("t3_expl_centre", explosion_on, 1);
        probe_e("t3_x_1_0", 5'd1, 5'd0, 1);
        probe_e("t3_x_0_1", 5'd0, 5'd1, 1);
        probe_e("t3_no_31_0", 5'd31, 5'd0, 0);
        step(1);
        probe_e("t3_no_0_31", 5'd0, 5'd31, 0);
        probe_e("t3_no_1_1", 5'd1, 5'd1, 0);
        wait_idle("t3_idle");
        step(1);

        // T4: chain reaction and back-pressured destroy arbiter
        destroy_ready = 1'b0;
        place_at(10'd128, 10'd128);
        step(2);
        place_at(10'd160, 10'd128);
        step(1);
        b_x = 10'd320; b_y = 10'd320;
        exp_q.push_back({5'd4, 5'd4});
        exp_q.push_back({5'd5, 5'd4});
        set_v(5'd4, 5'd4);
        n = 0;
        while (bomb_on && n < 40) begin
            step(1);
            n++;
        end
        chk("t4_slot0_expl", explosion_on, 1);
        probe_b("t4_slot1_still_fuse", 5'd5, 5'd4, 1);
        probe_e("t4_6_4_dark", 5'd6, 5'd4, 0);
        step(1);
        probe_b("t4_slot1_left_fuse", 5'd5, 5'd4, 0);
        probe_e("t4_chain_6_4", 5'd6, 5'd4, 1);
        hold = 0;
        for (int i = 0; i < 10; i++) begin
            if (destroy_valid && destroy_tx == 5'd4 && destroy_ty == 5'd4) hold++;
            step(1);
        end
        chk("t4_hold_cycles", hold, 10);
        destroy_ready = 1'b1;
        step(1);
        chk("t4_second_valid", destroy_valid, 1);
        chk("t4_second_tile", {destroy_tx, destroy_ty}, {5'd5, 5'd4});
        step(1);
        chk("t4_drained", destroy_valid, 0);
        wait_idle("t4_idle");
        step(1);

        // T6: reset during explosion with a pending destroy
        destroy_ready = 1'b0;
        place_at(10'd64, 10'd96);
        step(1);
        b_x = 10'd320; b_y = 10'd320;
        n = 0;
        while (!destroy_valid && n < 40) begin
            step(1);
            n++;
        end
        chk("t6_pending", destroy_valid, 1);
        set_v(5'd2, 5'd3);
        chk("t6_exploding", explosion_on, 1);
        Reset = 1'b1;
        step(1);
        chk("t6_valid", destroy_valid, 0);
        chk("t6_tile", {destroy_tx, destroy_ty}, 0);
        chk("t6_expl_on", explosion_on, 0);
        chk("t6_bomb_on", bomb_on, 0);
        chk("t6_free", bombs_free, 2);
        chk("t6_game_over", game_over, 0);
        Reset = 1'b0;
        destroy_ready = 1'b1;
        step(20);
        chk("t6_no_stale_req", destroy_valid, 0);
        step(1);

        // T5: bomberman caught in blast, then placement blocked
        place_at(10'd64, 10'd96);
        step(1);
        b_x = 10'd96; b_y = 10'd96;
        exp_q.push_back({5'd2, 5'd3});
        set_v(5'd3, 5'd3);
        n = 0;
        while (!explosion_on && n < 40) begin
            step(1);
            n++;
        end
        chk("t5_expl_on_player", explosion_on, 1);
        chk("t5_go_not_yet", game_over, 0);
        step(1);
        chk("t5_go_set", game_over, 1);
        b_x = 10'd320; b_y = 10'd320;
        place_at(10'd320, 10'd320);
        step(1);
        probe_b("t5_place_blocked", 5'd10, 5'd10, 0);
        wait_idle("t5_idle");
        chk("t5_go_sticky", game_over, 1);
        step(4);

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bomb_controller.md
# bomb_controller

Bomb resource scheduler for the bomberman game. Allocates a fixed pool of bomb slots on centre-button presses, runs each slot through fuse and explosion phases on a shared game tick, and arbitrates wall-destroy requests toward the breakable-wall logic. Also drives the per-pixel `bomb_on`/`explosion_on` layer enables and the sticky `game_over` flag. Sits beside `bomberman` and `box_top` in `bomberman_top`.

## Interface

**Parameters**
- `NUM_BOMBS`, default 2: number of bomb slots.
- `TICK_DIV`, default 1_000_000: `sys_clk` cycles per game tick (10 ms at 100 MHz).
- `FUSE_TICKS`, default 300: fuse duration in ticks.
- `EXPL_TICKS`, default 50: explosion duration in ticks.

**Ports**
- `sys_clk` in 1: 100 MHz clock.
- `Reset` in 1: asynchronous, active-high.
- `place` in 1: debounced centre button (level).
- `b_x`, `b_y` in 10 each: bomberman pixel position.
- `v_x`, `v_y` in 10 each: current VGA pixel (hc/vc).
- `bomb_on` out 1: pixel lies on a fusing bomb tile.
- `explosion_on` out 1: pixel lies in an active explosion cross.
- `bomb_rgb`, `explosion_rgb` out 12 each: constant layer colours.
- `destroy_valid` out 1: destroy request pending.
- `destroy_tx`, `destroy_ty` out 5 each: centre tile of the exploding bomb.
- `destroy_ready` in 1: breakable-wall logic accepts the request.
- `game_over` out 1: sticky; bomberman was caught in an explosion.
- `bombs_free` out 2: count of IDLE slots.

## Operation

**Tiles.** Tile = pixel >> `TILE_SHIFT` (5), giving 5-bit tile coordinates. A bomb is placed at the tile of (`b_x`, `b_y`).

**Tick.** A prescaler counts 0..`TICK_DIV`-1 and asserts `tick` for one cycle at wrap.

**Place.** A rising edge of `place` (internally registered) is a request.
- The request is granted to the lowest-index IDLE slot, unless any non-IDLE slot already holds the same tile.
- If no slot is free, the request is dropped silently.
- `game_over`=1 blocks all placement.

**Slot FSM.**
- IDLE → FUSE on grant: latch the tile, set cnt = `FUSE_TICKS`-1.
- FUSE:
  - On `tick`, cnt decrements.
  - If cnt==0 on `tick`, go to EXPLODE with cnt = `EXPL_TICKS`-1 and set the slot's `req` flag.
  - Chain reaction: if the slot's tile lies inside any EXPLODE slot's cross, go to EXPLODE on the next cycle regardless of tick.
- EXPLODE:
  - On `tick`, cnt decrements.
  - If cnt==0 on `tick`, go to IDLE.
- A slot freed in cycle N is grantable from cycle N+1. A grant and an expiry in the same cycle never target the same slot.

**Explosion cross.** The centre tile plus its four orthogonal neighbours. Neighbours at tile 0 − 1 or tile 31 + 1 are omitted; there is no wrap.

**Destroy arbiter.**
- Among slots with `req` set, the lowest index wins.
- It presents `destroy_valid` with that slot's tile and holds it until `destroy_valid && destroy_ready`.
- On that handshake the winner's `req` clears. The next winner is presented the following cycle.
- `req` survives the slot returning to IDLE; it is cleared only by the handshake.

**Game over.** Set when the bomberman tile lies inside any EXPLODE cross. Sticky until `Reset`.

**Pixel enables.**
- `bomb_on` is the OR over FUSE slots of (v tile == slot tile).
- `explosion_on` is the OR over EXPLODE slots of the cross match.
- Both are combinational from `v_x`/`v_y`, so they are aligned with the other layer enables.

**Colours.**
- `bomb_rgb` = 12'h111.
- `explosion_rgb` = 12'hF80.

## Timing

- Reset values:
  - All slots IDLE; counters and prescaler 0; `req` cleared.
  - `destroy_valid`=0, `destroy_tx`/`destroy_ty`=0.
  - `game_over`=0, `bombs_free`=`NUM_BOMBS`, `bomb_on`=`explosion_on`=0.
- Reset mid-operation: everything returns to the reset values above. Any pending destroy request is discarded.
- Place latency:
  - `place` rising at edge N is registered at N+1.
  - The slot enters FUSE at N+2.
  - `bomb_on`/`bombs_free` reflect it from N+2.
- Fuse length: exactly `FUSE_TICKS` tick pulses after the grant.
- `destroy_valid` rises the cycle after FUSE→EXPLODE.
- `game_over` rises one cycle after the overlap starts.

## Structure

- Shared `bomberman_pkg` holds:
  - `TILE_SHIFT`.
  - Slot state encoding (IDLE/FUSE/EXPLODE).
  - The colour constants.
  - The `in_cross` tile-compare function.
- Sub-module `bomb_slot` holds one slot: FSM, counter, tile latch and `req` flag. It is instantiated `NUM_BOMBS` times in a generate loop.
- The top level holds the prescaler, place edge detect, allocator, destroy arbiter, game-over logic and pixel ORs.

## Test plan

Test parameters: `TICK_DIV`=4, `FUSE_TICKS`=3, `EXPL_TICKS`=2, `destroy_ready`=1 unless stated.

1. Place at b=(64,96) (tile 2,3) → slot0 FUSE; `bomb_on`=1 for v=(70,100); after 3 ticks `explosion_on`=1 at v tiles (1,3),(3,3),(2,2),(2,4); `destroy_valid` for one cycle with tx=2, ty=3; IDLE after 2 more ticks.
2. Three places at distinct tiles with `NUM_BOMBS`=2 → third dropped; `bombs_free` goes 2→1→0; second place at an occupied tile → dropped.
3. Bomb at tile (0,0) → cross covers only (0,0),(1,0),(0,1); v at tile (31,0) never lights.
4. Slot0 at (4,4) fuses; slot1 at (5,4) placed later → slot1 enters EXPLODE the cycle after slot0 does; with `destroy_ready` held 0 for 10 cycles, `destroy_valid` holds tile (4,4), then (4,4) then (5,4) are accepted on consecutive cycles.
5. Bomberman standing at tile (3,3) when a bomb at (2,3) explodes → `game_over`=1 stays set; subsequent `place` ignored.
6. Assert `Reset` during EXPLODE with a pending destroy → all outputs at reset values on the next edge; `destroy_valid`=0.
